// File: rtl/decoder_onehot_pipe.sv
// -----------------------------------------------------------------------------
// decoder_onehot_pipe
//
// Registered binary-to-one-hot decoder with a valid/ready output stage.
// A select code accepted on the input handshake is decoded and stored in a
// single output register, which is offered downstream until it is taken.
// Illegal codes (in_sel >= N_OUT) decode to all ones and raise out_err.
// Each accepted illegal code also bumps a saturating error counter.
//
// Parameters:
//   N_OUT     number of one-hot outputs (2 .. 2**SEL_W)
//   SEL_W     select width in bits
//   CNT_W     error counter width in bits
//   IDLE_HOLD 0: out_onehot/out_err are cleared when the word is taken
//             1: out_onehot/out_err keep the last word while out_valid=0
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   in_sel is valid this cycle
//   in_ready   block accepts in_sel this cycle (combinational)
//   in_sel     binary select code
//   out_valid  out_onehot / out_err hold a valid word
//   out_ready  downstream accepts the word this cycle
//   out_onehot decoded word
//   out_err    held word came from an illegal code
//   err_cnt    saturating count of accepted illegal codes
//   err_clr    synchronous clear of err_cnt (wins over an increment)
// -----------------------------------------------------------------------------
module decoder_onehot_pipe #(
  parameter int N_OUT     = 4,
  parameter int SEL_W     = 2,
  parameter int CNT_W     = 8,
  parameter int IDLE_HOLD = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_onehot,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr
);

  // Select widened by one bit so N_OUT itself (up to 2**SEL_W) is representable.
  typedef logic [SEL_W:0] sel_ext_t;
  localparam sel_ext_t N_OUT_EXT = sel_ext_t'(N_OUT);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             xfer_in;
  logic             xfer_out;
  logic [N_OUT-1:0] dec_word;
  logic             dec_illegal;

  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Occupancy state: the output register is either EMPTY or FULL.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the blocks are evaluated in.
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: a default assignment up front keeps this block free of latches
    // for any path that does not assign state_next explicitly.
    state_next = state;
    case (state)
      EMPTY: if (xfer_in)              state_next = FULL;
      FULL:  if (xfer_out && !xfer_in) state_next = EMPTY;
      default:                         state_next = EMPTY;
    endcase
  end

  // out_valid is a direct decode of the state flop, so it stays registered;
  // in_ready is the only combinational output.
  always_comb begin
    out_valid = (state == FULL);
    in_ready  = (state == EMPTY) || out_ready;
  end

  // ---------------------------------------------------------------------------
  // Decoder. When N_OUT == 2**SEL_W the range check is always true, so the
  // illegal branch disappears and out_err stays 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    dec_word    = '0;
    dec_illegal = 1'b0;
    if ({1'b0, in_sel} < N_OUT_EXT) begin
      for (int i = 0; i < N_OUT; i++) begin
        if ({1'b0, in_sel} == sel_ext_t'(i)) begin
          dec_word[i] = 1'b1;
        end
      end
    end else begin
      dec_word    = '1;
      dec_illegal = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output data register. A new word wins over a take in the same cycle, which
  // gives back-to-back throughput without a bubble.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_onehot <= '0;
      out_err    <= 1'b0;
    end else if (xfer_in) begin
      out_onehot <= dec_word;
      out_err    <= dec_illegal;
    end else if (xfer_out && (IDLE_HOLD == 0)) begin
      out_onehot <= '0;
      out_err    <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating error counter; a clear in the same cycle drops the increment.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (xfer_in && dec_illegal && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_decoder_onehot_pipe.sv
// -----------------------------------------------------------------------------
// tb_decoder_onehot_pipe
//
// Four decoder_onehot_pipe instances with different parameter sets share one
// stimulus stream (each takes the low bits of a 3-bit select it needs):
//   0: N_OUT=4 SEL_W=2 CNT_W=8 IDLE_HOLD=0  (defaults)
//   1: N_OUT=5 SEL_W=3 CNT_W=8 IDLE_HOLD=0
//   2: N_OUT=3 SEL_W=2 CNT_W=2 IDLE_HOLD=0
//   3: N_OUT=4 SEL_W=2 CNT_W=8 IDLE_HOLD=1
// A transaction-level reference model, one per instance, predicts every output.
// -----------------------------------------------------------------------------
module tb_decoder_onehot_pipe;

  localparam int P_N  [4] = '{4, 5, 3, 4};
  localparam int P_SW [4] = '{2, 3, 2, 2};
  localparam int P_CW [4] = '{8, 8, 2, 8};
  localparam int P_H  [4] = '{0, 0, 0, 1};

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       out_ready;
  logic       err_clr;
  logic [2:0] sel;

  logic       rdy_a, rdy_b, rdy_c, rdy_d;
  logic       vld_a, vld_b, vld_c, vld_d;
  logic       err_a, err_b, err_c, err_d;
  logic [3:0] oh_a, oh_d;
  logic [4:0] oh_b;
  logic [2:0] oh_c;
  logic [7:0] cnt_a, cnt_b, cnt_d;
  logic [1:0] cnt_c;

  int checks = 0;
  int errors = 0;

  // Reference model state per instance.
  bit          m_v   [4];
  logic [31:0] m_w   [4];
  bit          m_e   [4];
  int          m_c   [4];

  always #5 clk = ~clk;

  decoder_onehot_pipe #(.N_OUT(4), .SEL_W(2), .CNT_W(8), .IDLE_HOLD(0)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_a),
    .in_sel(sel[1:0]), .out_valid(vld_a), .out_ready(out_ready),
    .out_onehot(oh_a), .out_err(err_a), .err_cnt(cnt_a), .err_clr(err_clr));

  decoder_onehot_pipe #(.N_OUT(5), .SEL_W(3), .CNT_W(8), .IDLE_HOLD(0)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_b),
    .in_sel(sel), .out_valid(vld_b), .out_ready(out_ready),
    .out_onehot(oh_b), .out_err(err_b), .err_cnt(cnt_b), .err_clr(err_clr));

  decoder_onehot_pipe #(.N_OUT(3), .SEL_W(2), .CNT_W(2), .IDLE_HOLD(0)) dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_c),
    .in_sel(sel[1:0]), .out_valid(vld_c), .out_ready(out_ready),
    .out_onehot(oh_c), .out_err(err_c), .err_cnt(cnt_c), .err_clr(err_clr));

  decoder_onehot_pipe #(.N_OUT(4), .SEL_W(2), .CNT_W(8), .IDLE_HOLD(1)) dut_d (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_d),
    .in_sel(sel[1:0]), .out_valid(vld_d), .out_ready(out_ready),
    .out_onehot(oh_d), .out_err(err_d), .err_cnt(cnt_d), .err_clr(err_clr));

  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_v[i] = 1'b0;
      m_w[i] = '0;
      m_e[i] = 1'b0;
      m_c[i] = 0;
    end
  endtask

  // Advance one clock: predict each instance's register contents from the
  // inputs present before the edge, then commit after the edge.
  task automatic tick();
    bit          nv [4];
    logic [31:0] nw [4];
    bit          ne [4];
    int          nc [4];
    for (int i = 0; i < 4; i++) begin
      int  s;
      bit  ill, rdy, tin, tout;
      s    = int'(sel) % (1 << P_SW[i]);
      ill  = (s >= P_N[i]);
      rdy  = !m_v[i] || out_ready;
      tin  = in_valid && rdy;
      tout = m_v[i] && out_ready;
      nv[i] = m_v[i];
      nw[i] = m_w[i];
      ne[i] = m_e[i];
      nc[i] = m_c[i];
      if (tin) begin
        nv[i] = 1'b1;
        nw[i] = ill ? ((32'd1 << P_N[i]) - 32'd1) : (32'd1 << s);
        ne[i] = ill;
      end else if (tout) begin
        nv[i] = 1'b0;
        if (P_H[i] == 0) begin
          nw[i] = '0;
          ne[i] = 1'b0;
        end
      end
      if (err_clr)
        nc[i] = 0;
      else if (tin && ill && (m_c[i] < (1 << P_CW[i]) - 1))
        nc[i] = m_c[i] + 1;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      m_v[i] = nv[i];
      m_w[i] = nw[i];
      m_e[i] = ne[i];
      m_c[i] = nc[i];
    end
  endtask

  // Compare every output of every instance against the model.
  task automatic check_all(input string tag);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ow, oc;
      logic        ov, oe, orr;
      case (i)
        0:       begin ow = 32'(oh_a); oc = 32'(cnt_a); ov = vld_a; oe = err_a; orr = rdy_a; end
        1:       begin ow = 32'(oh_b); oc = 32'(cnt_b); ov = vld_b; oe = err_b; orr = rdy_b; end
        2:       begin ow = 32'(oh_c); oc = 32'(cnt_c); ov = vld_c; oe = err_c; orr = rdy_c; end
        default: begin ow = 32'(oh_d); oc = 32'(cnt_d); ov = vld_d; oe = err_d; orr = rdy_d; end
      endcase
      chk($sformatf("%s[%0d].out_valid",  tag, i), 32'(ov),  32'(m_v[i]));
      chk($sformatf("%s[%0d].out_onehot", tag, i), ow,       m_w[i]);
      chk($sformatf("%s[%0d].out_err",    tag, i), 32'(oe),  32'(m_e[i]));
      chk($sformatf("%s[%0d].err_cnt",    tag, i), oc,       32'(m_c[i]));
      chk($sformatf("%s[%0d].in_ready",   tag, i), 32'(orr), 32'(!m_v[i] || out_ready));
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    sel       = '0;
    model_reset();

    // Reset state.
    #2;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all("reset_release");

    // Back-to-back decode of every legal code on the default instance.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sel = 3'(k);
      tick();
      check_all($sformatf("stream%0d", k));
      chk($sformatf("stream%0d.oh_a", k), 32'(oh_a), 32'd1 << k);
      chk($sformatf("stream%0d.vld_a", k), 32'(vld_a), 32'd1);
      chk($sformatf("stream%0d.cnt_a", k), 32'(cnt_a), 32'd0);
    end

    // Out-of-range code on the 5-output instance, then its top legal code.
    sel = 3'd6;
    tick();
    check_all("illegal6");
    chk("illegal6.oh_b",  32'(oh_b),  32'h1f);
    chk("illegal6.err_b", 32'(err_b), 32'd1);
    chk("illegal6.cnt_b", 32'(cnt_b), 32'd1);
    sel = 3'd4;
    tick();
    check_all("legal4");
    chk("legal4.oh_b",  32'(oh_b),  32'h10);
    chk("legal4.err_b", 32'(err_b), 32'd0);
    chk("legal4.cnt_b", 32'(cnt_b), 32'd1);

    // Backpressure: the held word and in_ready must not move while stalled.
    sel = 3'd2;
    tick();
    check_all("bp_load");
    out_ready = 1'b0;
    sel       = 3'd1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_all($sformatf("bp_stall%0d", k));
      chk($sformatf("bp_stall%0d.oh_a", k), 32'(oh_a), 32'h4);
      chk($sformatf("bp_stall%0d.rdy_a", k), 32'(rdy_a), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check_all("bp_release");
    chk("bp_release.oh_a", 32'(oh_a), 32'h2);

    // Saturation on the 2-bit counter instance, then clear vs increment.
    in_valid = 1'b0;
    err_clr  = 1'b1;
    tick();
    check_all("pre_clr");
    err_clr  = 1'b0;
    in_valid = 1'b1;
    sel      = 3'd3;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_all($sformatf("sat%0d", k));
      chk($sformatf("sat%0d.cnt_c", k), 32'(cnt_c), (k < 3) ? 32'(k + 1) : 32'd3);
    end
    err_clr = 1'b1;
    tick();
    check_all("clr_wins");
    chk("clr_wins.cnt_c", 32'(cnt_c), 32'd0);
    chk("clr_wins.oh_c",  32'(oh_c),  32'h7);
    err_clr = 1'b0;

    // IDLE_HOLD: take word 1000 with nothing behind it.
    sel = 3'd3;
    tick();
    check_all("idle_load");
    in_valid = 1'b0;
    tick();
    check_all("idle_drain");
    chk("idle_drain.oh_a",  32'(oh_a),  32'h0);
    chk("idle_drain.oh_d",  32'(oh_d),  32'h8);
    chk("idle_drain.vld_a", 32'(vld_a), 32'd0);
    chk("idle_drain.vld_d", 32'(vld_d), 32'd0);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      err_clr   = ($urandom_range(0, 31) == 0);
      sel       = 3'($urandom);
      tick();
      check_all($sformatf("rnd%0d", k));
    end

    // Asynchronous reset while a word is stalled.
    err_clr   = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    sel       = 3'd7;
    tick();
    out_ready = 1'b0;
    tick();
    check_all("pre_areset");
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("areset");
    chk("areset.vld_a", 32'(vld_a), 32'd0);
    chk("areset.cnt_b", 32'(cnt_b), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check_all("areset_release");
    chk("areset_release.rdy_a", 32'(rdy_a), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
